// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller covering load-use stalls, taken-branch flushes and
// multi-cycle mul/div waits with a timeout. Define HAZARD_PERF_CNT_EN to add STALL_COUNT/FLUSH_COUNT.
module hazard_ctrl #(
    parameter logic [5:0] MULDIV_TIMEOUT = 6'd40
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_REG_READ_ADDR1,
    input  logic [4:0]  ID_REG_READ_ADDR2,
    input  logic [4:0]  EX_REG_WRITE_ADDR,
    input  logic [3:0]  EX_DATA_MEM_READ,
    input  logic        EX_BRANCH_TAKEN,
    input  logic        EX_MULDIV_START,
    input  logic        MULDIV_DONE,
    output logic        PC_STALL,
    output logic        IF_ID_STALL,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_STALL,
    output logic        ID_EX_BUBBLE,
    output logic        EX_MEM_BUBBLE,
    output logic        HAZARD_ERROR,
`ifdef HAZARD_PERF_CNT_EN
    output logic [1:0]  STATE,
    output logic [31:0] STALL_COUNT,
    output logic [31:0] FLUSH_COUNT
`else
    output logic [1:0]  STATE
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_MULDIV = 2'b01,
        ST_ERROR  = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_wait_cnt;
    logic       w_load_use;
    logic       w_muldiv_wait;
    logic       w_unused;

    // Only bit 3 of the load control matters here; the size/sign bits are deliberately ignored.
    assign w_unused = ^EX_DATA_MEM_READ[2:0];

    assign w_load_use = EX_DATA_MEM_READ[3]
                     && (EX_REG_WRITE_ADDR != 5'd0)
                     && ((EX_REG_WRITE_ADDR == ID_REG_READ_ADDR1)
                      || (EX_REG_WRITE_ADDR == ID_REG_READ_ADDR2));

    assign w_muldiv_wait = EX_MULDIV_START && !MULDIV_DONE;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_RUN) begin
                r_wait_cnt <= '0;
            end else if ((r_state == ST_MULDIV) && !MULDIV_DONE && (r_wait_cnt != 6'h3F)) begin
                r_wait_cnt <= r_wait_cnt + 6'd1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (!EX_BRANCH_TAKEN && w_muldiv_wait) begin
                    w_next_state = ST_MULDIV;
                end
            end
            ST_MULDIV: begin
                if (MULDIV_DONE) begin
                    w_next_state = ST_RUN;
                end else if (r_wait_cnt == (MULDIV_TIMEOUT - 6'd1)) begin
                    w_next_state = ST_ERROR;
                end
            end
            ST_ERROR: w_next_state = ST_ERROR;
            default:  w_next_state = ST_RUN;
        endcase
    end

    always_comb begin
        PC_STALL      = 1'b0;
        IF_ID_STALL   = 1'b0;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_STALL   = 1'b0;
        ID_EX_BUBBLE  = 1'b0;
        EX_MEM_BUBBLE = 1'b0;
        HAZARD_ERROR  = 1'b0;
        if (!RESET) begin
            case (r_state)
                ST_RUN: begin
                    // Branch beats mul/div beats load-use; a losing event drives nothing.
                    if (EX_BRANCH_TAKEN) begin
                        IF_ID_FLUSH  = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                    end else if (EX_MULDIV_START) begin
                        if (!MULDIV_DONE) begin
                            PC_STALL      = 1'b1;
                            IF_ID_STALL   = 1'b1;
                            ID_EX_STALL   = 1'b1;
                            EX_MEM_BUBBLE = 1'b1;
                        end
                    end else if (w_load_use) begin
                        PC_STALL     = 1'b1;
                        IF_ID_STALL  = 1'b1;
                        ID_EX_BUBBLE = 1'b1;
                    end
                end
                ST_MULDIV: begin
                    if (!MULDIV_DONE) begin
                        PC_STALL      = 1'b1;
                        IF_ID_STALL   = 1'b1;
                        ID_EX_STALL   = 1'b1;
                        EX_MEM_BUBBLE = 1'b1;
                    end
                end
                ST_ERROR: begin
                    PC_STALL      = 1'b1;
                    IF_ID_STALL   = 1'b1;
                    ID_EX_STALL   = 1'b1;
                    EX_MEM_BUBBLE = 1'b1;
                    HAZARD_ERROR  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign STATE = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (PC_STALL) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (IF_ID_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign STALL_COUNT = r_stall_cnt;
    assign FLUSH_COUNT = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle mul/div and timeout
// sequences, then randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 40;
    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_LU     = 6'b110010;
    localparam logic [5:0] C_BRANCH = 6'b001010;
    localparam logic [5:0] C_STALL  = 6'b110101;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] mr;
        logic       br;
        logic       st;
        logic       dn;
    } in_t;

    typedef struct {
        in_t        in;
        logic [5:0] exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  ID_REG_READ_ADDR1, ID_REG_READ_ADDR2, EX_REG_WRITE_ADDR;
    logic [3:0]  EX_DATA_MEM_READ;
    logic        EX_BRANCH_TAKEN, EX_MULDIV_START, MULDIV_DONE;
    logic        PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_BUBBLE, EX_MEM_BUBBLE;
    logic        HAZARD_ERROR;
    logic [1:0]  STATE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] STALL_COUNT, FLUSH_COUNT;
`endif
    logic [8:0]  w_dut;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.MULDIV_TIMEOUT(6'(TIMEOUT))) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .ID_REG_READ_ADDR1 (ID_REG_READ_ADDR1),
        .ID_REG_READ_ADDR2 (ID_REG_READ_ADDR2),
        .EX_REG_WRITE_ADDR (EX_REG_WRITE_ADDR),
        .EX_DATA_MEM_READ  (EX_DATA_MEM_READ),
        .EX_BRANCH_TAKEN   (EX_BRANCH_TAKEN),
        .EX_MULDIV_START   (EX_MULDIV_START),
        .MULDIV_DONE       (MULDIV_DONE),
        .PC_STALL          (PC_STALL),
        .IF_ID_STALL       (IF_ID_STALL),
        .IF_ID_FLUSH       (IF_ID_FLUSH),
        .ID_EX_STALL       (ID_EX_STALL),
        .ID_EX_BUBBLE      (ID_EX_BUBBLE),
        .EX_MEM_BUBBLE     (EX_MEM_BUBBLE),
        .HAZARD_ERROR      (HAZARD_ERROR),
`ifdef HAZARD_PERF_CNT_EN
        .STALL_COUNT       (STALL_COUNT),
        .FLUSH_COUNT       (FLUSH_COUNT),
`endif
        .STATE             (STATE)
    );

    always #5 CLK = ~CLK;

    assign w_dut = {PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_BUBBLE,
                    EX_MEM_BUBBLE, HAZARD_ERROR, STATE};

    // Reference model: pipeline mode (0 run, 1 waiting on mul/div, 2 error) and cycles waited.
    int          m_mode   = 0;
    int          m_waited = 0;
    int unsigned m_stalls = 0;
    int unsigned m_flushes = 0;
    in_t         cur = '{rst: 1'b1, default: '0};

    function automatic in_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [3:0] mr,
                               input logic br, input logic st, input logic dn);
        in_t v;
        v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.mr = mr; v.br = br; v.st = st; v.dn = dn;
        return v;
    endfunction

    function automatic logic [8:0] model_out(input in_t v);
        logic       lu;
        logic [5:0] c;
        logic       err;
        c   = C_NONE;
        err = 1'b0;
        lu  = v.mr[3] && (v.rd != 5'd0) && ((v.rd == v.rs1) || (v.rd == v.rs2));
        if (!v.rst) begin
            if (m_mode == 0) begin
                if (v.br)      c = C_BRANCH;
                else if (v.st) c = v.dn ? C_NONE : C_STALL;
                else if (lu)   c = C_LU;
            end else if (m_mode == 1) begin
                c = v.dn ? C_NONE : C_STALL;
            end else begin
                c   = C_STALL;
                err = 1'b1;
            end
        end
        return {c, err, 2'(m_mode)};
    endfunction

    task automatic model_step(input in_t v);
        logic [8:0] o;
        o = model_out(v);
        if (v.rst) begin
            m_mode = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (o[8]) m_stalls++;
            if (o[6]) m_flushes++;
            case (m_mode)
                0: if (!v.br && v.st && !v.dn) begin m_mode = 1; m_waited = 0; end
                1: begin
                    if (v.dn) m_mode = 0;
                    else begin
                        m_waited++;
                        if (m_waited == TIMEOUT) m_mode = 2;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Advances one clock: the model takes the edge with the held inputs, then new inputs settle.
    task automatic drive(input in_t v);
        model_step(cur);
        @(negedge CLK);
        cur = v;
        RESET = v.rst; ID_REG_READ_ADDR1 = v.rs1; ID_REG_READ_ADDR2 = v.rs2;
        EX_REG_WRITE_ADDR = v.rd; EX_DATA_MEM_READ = v.mr;
        EX_BRANCH_TAKEN = v.br; EX_MULDIV_START = v.st; MULDIV_DONE = v.dn;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [8:0] exp);
        check(name, 32'(w_dut), 32'(exp));
    endtask

    vec_t vecs[13];
    in_t  idle, mstart;
    int   n, ok;
    logic saw_err;

    initial begin
        RESET = cur.rst; ID_REG_READ_ADDR1 = '0; ID_REG_READ_ADDR2 = '0; EX_REG_WRITE_ADDR = '0;
        EX_DATA_MEM_READ = '0; EX_BRANCH_TAKEN = 0; EX_MULDIV_START = 0; MULDIV_DONE = 0;
        idle   = mk(0, 0, 0, 0, 4'b0000, 0, 0, 0);
        mstart = mk(0, 0, 0, 0, 4'b0000, 0, 1, 0);

        vecs[0]  = '{mk(0,  1, 5,  5, 4'b1000, 0, 0, 0), C_LU};
        vecs[1]  = '{mk(0,  1, 5,  5, 4'b0000, 0, 0, 0), C_NONE};
        vecs[2]  = '{mk(0,  5, 2,  5, 4'b1000, 0, 0, 0), C_LU};
        vecs[3]  = '{mk(0,  0, 3,  0, 4'b1000, 0, 0, 0), C_NONE};
        vecs[4]  = '{mk(0,  5, 5,  5, 4'b0111, 0, 0, 0), C_NONE};
        vecs[5]  = '{mk(0,  5, 0,  5, 4'b1000, 1, 0, 0), C_BRANCH};
        vecs[6]  = '{mk(0,  3, 4,  9, 4'b0000, 1, 0, 0), C_BRANCH};
        vecs[7]  = '{mk(0,  5, 5,  5, 4'b1000, 0, 1, 1), C_NONE};
        vecs[8]  = '{mk(0,  0, 0,  0, 4'b0000, 0, 0, 0), C_NONE};
        vecs[9]  = '{mk(0, 31, 7, 31, 4'b1111, 0, 0, 0), C_LU};
        vecs[10] = '{mk(0,  6, 8,  7, 4'b1000, 0, 0, 0), C_NONE};
        vecs[11] = '{mk(0,  2, 9,  9, 4'b1000, 1, 1, 0), C_BRANCH};
        vecs[12] = '{mk(0,  2, 9,  9, 4'b1000, 0, 0, 0), C_LU};

        // Controls stay low while reset is held, even with a live load-use hazard.
        drive(mk(1, 5, 5, 5, 4'b1000, 0, 0, 0));
        check_out("reset_outputs", {C_NONE, 3'b000});
        drive(idle);
        check_out("after_reset", {C_NONE, 3'b000});

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].in);
            check_out($sformatf("vec%0d", i), {vecs[i].exp, 3'b000});
        end

`ifdef HAZARD_PERF_CNT_EN
        drive(mk(1, 0, 0, 0, 4'b0000, 0, 0, 0));
        for (int i = 0; i < 3; i++) drive(mk(0, 4, 0, 4, 4'b1000, 0, 0, 0));
        for (int i = 0; i < 2; i++) drive(mk(0, 0, 0, 0, 4'b0000, 1, 0, 0));
        drive(idle);
        check("stall_count", STALL_COUNT, 32'd3);
        check("flush_count", FLUSH_COUNT, 32'd2);
`endif

        // Mul/div finishing after 33 wait cycles: 34 stalled cycles in total.
        n = 0; ok = 0;
        drive(mstart);
        check_out("muldiv_enter", {C_STALL, 3'b000});
        n += int'(PC_STALL);
        for (int i = 0; i < 33; i++) begin
            drive(mstart);
            if (w_dut === {C_STALL, 3'b001}) ok++;
            n += int'(PC_STALL);
        end
        check("muldiv_wait_cycles", ok, 33);
        drive(mk(0, 0, 0, 0, 4'b0000, 0, 1, 1));
        check_out("muldiv_done", {C_NONE, 3'b001});
        n += int'(PC_STALL);
        drive(idle);
        check_out("muldiv_back_to_run", {C_NONE, 3'b000});
        check("muldiv_stall_cycles", n, 34);

        // Mul/div that never finishes: ERROR after 40 wait cycles, sticky until reset.
        drive(mstart);
        check_out("timeout_enter", {C_STALL, 3'b000});
        n = 0; saw_err = 1'b0;
        for (int k = 0; k < 100 && !saw_err; k++) begin
            drive(mstart);
            if (STATE === 2'b01) n++;
            else saw_err = 1'b1;
        end
        check("timeout_cycles", n, TIMEOUT);
        check_out("timeout_error", {C_STALL, 3'b110});
        drive(mk(0, 5, 5, 5, 4'b1000, 1, 1, 1));
        check_out("error_ignores_inputs", {C_STALL, 3'b110});
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            drive(mk(0, 0, 0, 0, 4'b0000, 0, 0, 1));
            if (w_dut === {C_STALL, 3'b110}) ok++;
        end
        check("error_sticky", ok, 5);
        drive(mk(1, 5, 5, 5, 4'b1000, 0, 0, 0));
        check_out("reset_in_error", {C_NONE, 3'b010});
        drive(idle);
        check_out("error_cleared", {C_NONE, 3'b000});

        // Reset in the middle of a mul/div wait.
        drive(mstart);
        for (int i = 0; i < 5; i++) drive(mstart);
        drive(mk(1, 0, 0, 0, 4'b0000, 0, 1, 0));
        check_out("reset_mid_muldiv", {C_NONE, 3'b001});
        drive(idle);
        check_out("after_mid_reset", {C_NONE, 3'b000});

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive(mk(($urandom_range(0, 99) == 0),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 19) == 0)));
            check_out($sformatf("rand%0d", i), model_out(cur));
        end
`ifdef HAZARD_PERF_CNT_EN
        drive(mk(0, 0, 0, 0, 4'b0000, 0, 0, 1));
        check("rand_stall_count", STALL_COUNT, m_stalls);
        check("rand_flush_count", FLUSH_COUNT, m_flushes);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_TIMEOUT, default 6'd40, max cycles allowed in MULDIV wait before error.
REQ-002 SHALL have ports, one per line:
  CLK  input  1  clock, all state updates on posedge
  RESET  input  1  synchronous, active-high reset
  ID_REG_READ_ADDR1  input  5  rs1 of instruction in ID
  ID_REG_READ_ADDR2  input  5  rs2 of instruction in ID
  EX_REG_WRITE_ADDR  input  5  rd of instruction in EX
  EX_DATA_MEM_READ  input  4  EX load control, bit 3 = load enable
  EX_BRANCH_TAKEN  input  1  branch/jump taken, resolved in EX
  EX_MULDIV_START  input  1  EX holds multi-cycle M-extension op
  MULDIV_DONE  input  1  mul/div unit result valid, 1-cycle pulse
  PC_STALL  output  1  hold PC
  IF_ID_STALL  output  1  hold IF/ID register
  IF_ID_FLUSH  output  1  load NOP into IF/ID
  ID_EX_STALL  output  1  hold ID/EX register
  ID_EX_BUBBLE  output  1  load all-zero controls into ID/EX
  EX_MEM_BUBBLE  output  1  load all-zero controls into EX/MEM
  HAZARD_ERROR  output  1  sticky muldiv timeout flag
  STATE  output  2  current state, debug
REQ-003 CLK and RESET SHALL be one clock domain; reset is synchronous and active-high.

Function
REQ-004 SHALL hold a registered state: RUN=2'b00, MULDIV=2'b01, ERROR=2'b10; 2'b11 SHALL go to RUN on next edge.
REQ-005 Control outputs SHALL be combinational from current state and inputs, so a hazard is covered in the cycle it is visible.
REQ-006 Load-use (RUN): EX_DATA_MEM_READ[3]=1, EX_REG_WRITE_ADDR!=0, and it equals ID_REG_READ_ADDR1 or ID_REG_READ_ADDR2 -> PC_STALL, IF_ID_STALL, ID_EX_BUBBLE =1 for that cycle only; state stays RUN.
REQ-007 Branch (RUN): EX_BRANCH_TAKEN=1 -> IF_ID_FLUSH=1, ID_EX_BUBBLE=1, no stalls; state stays RUN.
REQ-008 Priority in RUN: EX_BRANCH_TAKEN over EX_MULDIV_START over load-use; lower-priority event SHALL produce no output that cycle.
REQ-009 RUN with EX_MULDIV_START=1 and MULDIV_DONE=0 -> PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_BUBBLE =1; next state MULDIV; wait counter cleared to 0.
REQ-010 EX_MULDIV_START and MULDIV_DONE both 1 in RUN -> no stall, stay RUN (single-cycle op).
REQ-011 MULDIV: same four outputs =1 while MULDIV_DONE=0; counter +1 per cycle; MULDIV_DONE=1 -> all outputs 0 that cycle, next RUN.
REQ-012 MULDIV with counter == MULDIV_TIMEOUT-1 and MULDIV_DONE=0 -> next ERROR; counter 6 bits, SHALL NOT wrap.
REQ-013 ERROR: HAZARD_ERROR=1, PC_STALL=IF_ID_STALL=ID_EX_STALL=1, EX_MEM_BUBBLE=1; exit only by RESET.
REQ-014 Load-use and branch inputs SHALL be ignored in MULDIV and ERROR.
REQ-015 With no event in RUN, all control outputs SHALL be 0.

Reset
REQ-016 RESET=1 at posedge -> state RUN, counter 0, HAZARD_ERROR 0, perf counters 0; takes priority in every state, including mid-MULDIV.
REQ-017 While RESET=1, control outputs SHALL be 0.

Configuration
REQ-018 Macro HAZARD_PERF_CNT_EN defined -> adds outputs STALL_COUNT[31:0] (+1 each cycle PC_STALL=1) and FLUSH_COUNT[31:0] (+1 each cycle IF_ID_FLUSH=1), wrapping at 2^32; undefined -> ports and logic absent, all other behaviour identical.

Verification
REQ-019 EX load rd=x5, ID rs2=x5 -> one cycle PC_STALL=IF_ID_STALL=ID_EX_BUBBLE=1, then 0; STATE=00.
REQ-020 EX load rd=x0, ID rs1=x0 -> no stall.
REQ-021 EX_BRANCH_TAKEN=1 with load-use also true -> IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_STALL=0.
REQ-022 EX_MULDIV_START, MULDIV_DONE after 33 cycles -> stalls high 34 cycles total, STATE 01 then 00, HAZARD_ERROR=0.
REQ-023 EX_MULDIV_START, no MULDIV_DONE -> STATE=10 after 40 MULDIV cycles, HAZARD_ERROR=1 until RESET; RESET mid-MULDIV -> STATE=00 next edge.
REQ-024 With HAZARD_PERF_CNT_EN: 3 load-use stalls + 2 branches -> STALL_COUNT=3, FLUSH_COUNT=2.
